// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the ALU family (used by alu_seq_shifter).
//
// Contents:
//   OP_SLL / OP_SRL / OP_SRA / OP_ROL / OP_ROR : 4-bit op codes
//   state_e                                    : sequential shifter FSM states
//
// Rotate op codes are always defined here. Whether the shifter treats them as
// legal depends on the ALU_SHIFT_ROT_EN macro, evaluated in alu_seq_shifter.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_ROL = 4'h8;
  localparam logic [3:0] OP_ROR = 4'h9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_shifter.sv
// ---------------------------------------------------------------------------
// alu_seq_shifter -- multi-cycle shifter, one bit per clock.
//
// Configuration macro: ALU_SHIFT_ROT_EN
//   defined   : op 4'h8 (ROL) and 4'h9 (ROR) rotate one bit per SHIFT cycle.
//   undefined : 4'h8 and 4'h9 are illegal (y=0, err=1).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready high only in IDLE)
//   op, a, b              op code, value to shift, shift amount (b[SW-1:0])
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   y                     shifted result
//   carry, overflow       always 0
//   zero, negative        y == 0, y[WIDTH-1]
//   err                   unsupported op code
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds its payload stable while valid is high and
// ready is low. Requests seen while busy are ignored.
//
// The FSM state is held in state_q for checkers to observe.
// ---------------------------------------------------------------------------
module alu_seq_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SW-1:0]    count_q, count_d;
  logic [3:0]       op_q, op_d;
  logic             err_q, err_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] shifted;
  logic             unused_b;

  assign shamt    = b[SW-1:0];
  assign unused_b = ^b[WIDTH-1:SW];

  function automatic logic op_legal(input logic [3:0] o);
    logic ok;
    case (o)
      OP_SLL, OP_SRL, OP_SRA: ok = 1'b1;
`ifdef ALU_SHIFT_ROT_EN
      OP_ROL, OP_ROR:         ok = 1'b1;
`endif
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // One-bit step of the working register for the captured op.
  function automatic logic [WIDTH-1:0] step(input logic [3:0] o,
                                            input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (o)
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
      OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
`ifdef ALU_SHIFT_ROT_EN
      OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[WIDTH-1:1]};
`endif
      default: r = v;
    endcase
    return r;
  endfunction

  assign shifted = step(op_q, work_q);

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    y_d         = y_q;
    count_d     = count_q;
    op_d        = op_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d       = op;
          work_d     = a;
          in_ready_d = 1'b0;
          if (!op_legal(op)) begin
            y_d         = '0;
            err_d       = 1'b1;
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else if (shamt == '0) begin
            y_d         = a;
            err_d       = 1'b0;
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            count_d = shamt;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d  = shifted;
        count_d = count_q - SW'(1);
        // The edge performing the final shift also publishes the result.
        if (count_q == SW'(1)) begin
          y_d         = shifted;
          err_d       = 1'b0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase

    // Flags follow y_d, so they only change when a new result is loaded.
    zero_d = (y_d == '0);
    neg_d  = y_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      y_q         <= '0;
      count_q     <= '0;
      op_q        <= '0;
      err_q       <= 1'b0;
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      y_q         <= y_d;
      count_q     <= count_d;
      op_q        <= op_d;
      err_q       <= err_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign err       = err_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign carry     = 1'b0;
  assign overflow  = 1'b0;

endmodule

// File: tb/tb_alu_seq_shifter.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_shifter -- scoreboard bench for alu_seq_shifter (WIDTH = 32).
// Expected results and first-valid cycles are queued when a request is
// accepted; a monitor on the falling edge compares whatever the DUT presents.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq_shifter;

  localparam int W  = 32;
  localparam int SW = $clog2(W);
  localparam int EW = W + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y;
  logic         carry, overflow, zero, negative, err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit hold     = 1'b1;
  bit seen     = 1'b0;

  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  alu_seq_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .carry(carry), .overflow(overflow), .zero(zero),
    .negative(negative), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: random acceptance unless back-pressure is being forced.
  always @(posedge clk) begin
    #1;
    out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit legal(input logic [3:0] o);
    bit ok;
    ok = (o == 4'h5) || (o == 4'h6) || (o == 4'h7);
`ifdef ALU_SHIFT_ROT_EN
    ok = ok || (o == 4'h8) || (o == 4'h9);
`endif
    return ok;
  endfunction

  // Packed as {err, negative, zero, y}.
  function automatic logic [EW-1:0] model(input logic [3:0] o, input logic [W-1:0] av, input int sh);
    logic [W-1:0] r;
    logic         e;
    e = 1'b0;
    r = '0;
    if (!legal(o)) e = 1'b1;
    else case (o)
      4'h5: r = av << sh;
      4'h6: r = av >> sh;
      4'h7: r = W'($signed(av) >>> sh);
      4'h8: r = (sh == 0) ? av : ((av << sh) | (av >> (W - sh)));
      default: r = (sh == 0) ? av : ((av >> sh) | (av << (W - sh)));
    endcase
    return {e, r[W-1], (r == '0), r};
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    int waited;
    int sh;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=0 required=1 after %0d cycles", waited);
      return;
    end
    in_valid = 1'b1;
    op = o;
    a  = av;
    b  = bv;
    sh = int'(bv[SW-1:0]);
    exp_q.push_back(model(o, av, sh));
    exp_cyc_q.push_back(cyc + (legal(o) ? sh + 1 : 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      check("ready_valid_exclusive", 64'(in_ready & out_valid), 64'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: y=%0h err=%0b required=no output", y, err);
        end else begin
          check("result", 64'({err, negative, zero, y}), 64'(exp_q[0]));
          check("carry_overflow", 64'({carry, overflow}), 64'd0);
          if (!seen) begin
            check("latency", 64'(cyc), 64'(exp_cyc_q[0]));
            seen = 1'b1;
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] ops[8];
    ops = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF, 4'h0, 4'h3};

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_flags", 64'({err, negative, zero, y}), 64'({1'b0, 1'b0, 1'b1, 32'h0}));
    rst_n = 1'b1;
    hold  = 1'b0;

    // Directed cases.
    send(4'h5, 32'h0000_0001, 32'd4);
    send(4'h7, 32'hFFFF_FFE0, 32'd3);
    send(4'h6, 32'hFFFF_FFE0, 32'd3);
    send(4'h6, 32'h0000_0010, 32'h0000_0022);
    send(4'h6, 32'h1234_5678, 32'h0000_0040);
    send(4'hF, 32'hDEAD_BEEF, 32'd7);
    send(4'h8, 32'h8000_0001, 32'd1);
    send(4'h9, 32'h8000_0001, 32'd1);
    send(4'h5, 32'h0000_0001, 32'd31);
    send(4'h7, 32'h8000_0000, 32'd31);
    drain();

    // Back-pressure: result held, in_ready low, extra request ignored.
    hold = 1'b1;
    out_ready = 1'b0;
    send(4'h5, 32'h0000_00A5, 32'd2);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("bp_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      op = 4'h6;
      a  = 32'hFFFF_0000;
      b  = 32'd1;
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_y_hold", 64'(y), 64'h0000_0294);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hold = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    // Reset in the middle of a long shift.
    send(4'h6, 32'hF0F0_F0F0, 32'd10);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_flags", 64'({err, negative, zero, y}), 64'({1'b0, 1'b0, 1'b1, 32'h0}));
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("abort_no_result", 64'(out_valid), 64'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] o;
      o = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
      send(o, $urandom, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL global_timeout: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_shifter.md
ALU_SEQ_SHIFTER -- requirements
Module: alu_seq_shifter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, a power of two of at least 8.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  4  operation code: SLL=4'h5, SRL=4'h6, SRA=4'h7.
REQ-007 a  input  WIDTH  value to be shifted.
REQ-008 b  input  WIDTH  shift amount source; only b[$clog2(WIDTH)-1:0] (shamt) is used.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 y  output  WIDTH  shifted result.
REQ-012 carry, overflow  output  1 each  tied 0 for every operation.
REQ-013 zero  output  1  (y == 0).
REQ-014 negative  output  1  y[WIDTH-1].
REQ-015 err  output  1  high with the result of an unsupported op code.

Function
REQ-016 FSM states SHALL be IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-017 A request SHALL be accepted on a rising edge with in_valid && in_ready; op, a and shamt are captured at that edge.
REQ-018 On acceptance: shamt == 0 or illegal op -> DONE; otherwise -> SHIFT, with the count register loaded with shamt.
REQ-019 Each SHIFT cycle SHALL shift the working register by exactly one bit and decrement the count; the move to DONE SHALL happen on the edge that performs the last shift.
REQ-020 Shift fill: SLL inserts 0 at bit 0; SRL inserts 0 at bit WIDTH-1; SRA replicates bit WIDTH-1.
REQ-021 Latency: with the accept cycle numbered 0, out_valid SHALL first be high in cycle shamt+1 (cycle 1 for shamt 0 and for an illegal op).
REQ-022 An illegal op SHALL give y=0, err=1, zero=1; a legal op SHALL give err=0.
REQ-023 In DONE, y, zero, negative and err SHALL stay stable while out_ready=0; out_valid && out_ready SHALL return the FSM to IDLE on that edge.
REQ-024 in_valid while busy SHALL be ignored: no capture and no effect on the operation in progress.
REQ-025 Outside DONE, y, zero, negative and err SHALL keep their last values, and consumers SHALL ignore them.

Reset
REQ-026 rst_n low SHALL force, asynchronously: state=IDLE, in_ready=1, out_valid=0, y=0, count=0, err=0, zero=1, negative=0.
REQ-027 Reset during SHIFT or DONE SHALL abort the operation, and no result SHALL be presented after release.

Configuration
REQ-028 With macro ALU_SHIFT_ROT_EN defined: op 4'h8 (ROL) rotates left and op 4'h9 (ROR) rotates right, one bit per SHIFT cycle, with the same latency rule.
REQ-029 With ALU_SHIFT_ROT_EN undefined: 4'h8 and 4'h9 are illegal and follow REQ-022.

Structure
REQ-030 The op code constants (OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR) and the FSM state typedef SHALL live in the shared package alu_pkg, reused by alu.
REQ-031 The block SHALL be a single module with no sub-module; flag logic SHALL be inline.

Verification
REQ-032 SLL, a=32'h0000_0001, shamt=4 -> y=32'h0000_0010 in cycle 5, Z=0, N=0, C=0, V=0.
REQ-033 SRA, a=32'hFFFF_FFE0, shamt=3 -> y=32'hFFFF_FFFC in cycle 4, N=1; SRL with the same inputs -> y=32'h1FFF_FFFC, N=0.
REQ-034 SRL, a=32'h0000_0010, b=32'h0000_0022 (shamt=2) -> y=32'h0000_0004; shamt=0 -> y=a in cycle 1.
REQ-035 Back-pressure: out_ready=0 for 5 cycles after out_valid -> y held stable, in_ready=0, and a second in_valid is not captured.
REQ-036 Reset: rst_n pulsed low in cycle 2 of a shamt=10 shift -> immediate IDLE, out_valid never rises.
REQ-037 Illegal op 4'hF -> out_valid in cycle 1, y=0, err=1, Z=1; with ALU_SHIFT_ROT_EN, ROL 32'h8000_0001 by 1 -> 32'h0000_0003.
